gray_fetch: RTL

- Upstream feeder for the sobel edge stage.
- Generates sequential frame-buffer read addresses from the VGA timing position (pos_x, pos_y) and reads RGB444 pixels from a synchronous-read RAM.
- Converts each pixel to luminance and presents a WORD_SIZE gray pixel plus position tags delayed to match, ready to drive the edge stage's pixel and position inputs.
- Pure 3-stage pipeline with no backpressure.

---
 rtl/gray_fetch.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/gray_fetch.sv
// gray_fetch: frame-buffer fetch and luminance stage feeding the sobel edge unit.
// Turns the VGA timing position into sequential RAM read addresses. Each RGB444
// pixel that comes back becomes a WORD_SIZE gray value. Position tags travel
// beside it, so the outputs lag pos_x/pos_y by exactly three clocks.
// Optional build macro GRAY_FETCH_MINMAX_EN adds per-frame min/max statistics
// (frame_min, frame_max, frame_done).
module gray_fetch #(
  parameter int WORD_SIZE  = 4,
  parameter int COLOR_BITS = 4,
  parameter int H_ACTIVE   = 512,
  parameter int V_ACTIVE   = 384,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [10:0]             pos_x,
  input  logic [10:0]             pos_y,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_en,
  input  logic [3*COLOR_BITS-1:0] rd_data,
  output logic [WORD_SIZE-1:0]    gray_pixel,
  output logic [10:0]             pos_x_out,
  output logic [10:0]             pos_y_out,
  output logic                    pix_valid
`ifdef GRAY_FETCH_MINMAX_EN
  ,
  output logic [WORD_SIZE-1:0]    frame_min,
  output logic [WORD_SIZE-1:0]    frame_max,
  output logic                    frame_done
`endif
);

  localparam int SUM_W = COLOR_BITS + 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

  // Address counter and stage registers
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_en_q, rd_en_d;
  logic [10:0]           x1_q, x1_d, y1_q, y1_d;
  logic                  v2_q, v2_d;
  logic [10:0]           x2_q, x2_d, y2_q, y2_d;
  logic [WORD_SIZE-1:0]  gray_q, gray_d;
  logic                  valid_q, valid_d;
  logic [10:0]           pos_x_out_q, pos_x_out_d;
  logic [10:0]           pos_y_out_q, pos_y_out_d;

  logic                    in_win;
  logic [3*COLOR_BITS-1:0] rgb2;
  logic [COLOR_BITS-1:0]   chan [3];
  logic [SUM_W-1:0]        term [3];
  logic [SUM_W-1:0]        sum_w;

  // Visible window; row and column 0 are excluded, matching the edge stage.
  always_comb begin
    in_win = (pos_x >= 11'd1) && (pos_x <= 11'(H_ACTIVE)) &&
             (pos_y >= 11'd1) && (pos_y <= 11'(V_ACTIVE));
  end

  // Linear pixel counter: cleared on the pos_y == 0 row, stepped per visible pixel.
  always_comb begin
    addr_cnt_d = addr_cnt_q;
    if (pos_y == 11'd0) begin
      addr_cnt_d = '0;
    end else if (in_win) begin
      addr_cnt_d = (addr_cnt_q == ADDR_LAST) ? '0 : addr_cnt_q + ADDR_WIDTH'(1);
    end
  end

  // Stage 1: issue the RAM read; the address holds while outside the window.
  always_comb begin
    rd_addr_d = in_win ? addr_cnt_q : rd_addr_q;
    rd_en_d   = in_win;
    x1_d      = pos_x;
    y1_d      = pos_y;
  end

  // Stage 2: the RAM's own read register holds the pixel (rd_data). Only the tags
  // are registered here. rd_data is stale after an idle cycle, so it is masked
  // with the stage-2 valid bit before the luminance math.
  always_comb begin
    v2_d = rd_en_q;
    x2_d = x1_q;
    y2_d = y1_q;
    rgb2 = v2_q ? rd_data : '0;
  end

  // Split {R,G,B} and weight each channel (77/150/29, summing to 256).
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    localparam int WGT = (gi == 0) ? 77 : ((gi == 1) ? 150 : 29);
    assign chan[gi] = rgb2[(3 - gi) * COLOR_BITS - 1 -: COLOR_BITS];
    assign term[gi] = SUM_W'(WGT) * SUM_W'(chan[gi]);
  end

  // Luminance sum; cannot overflow because the weights total 256.
  always_comb begin
    sum_w = term[0] + term[1] + term[2];
  end

  // Stage 3: keep the top WORD_SIZE bits of the sum; out-of-window pixels emit 0.
  always_comb begin
    gray_d      = v2_q ? WORD_SIZE'(sum_w >> (SUM_W - WORD_SIZE)) : '0;
    valid_d     = v2_q;
    pos_x_out_d = x2_q;
    pos_y_out_d = y2_q;
  end

  // Pipeline registers, flushed by the asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_cnt_q  <= '0;
      rd_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      x1_q        <= '0;
      y1_q        <= '0;
      v2_q        <= 1'b0;
      x2_q        <= '0;
      y2_q        <= '0;
      gray_q      <= '0;
      valid_q     <= 1'b0;
      pos_x_out_q <= '0;
      pos_y_out_q <= '0;
    end else begin
      addr_cnt_q  <= addr_cnt_d;
      rd_addr_q   <= rd_addr_d;
      rd_en_q     <= rd_en_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      v2_q        <= v2_d;
      x2_q        <= x2_d;
      y2_q        <= y2_d;
      gray_q      <= gray_d;
      valid_q     <= valid_d;
      pos_x_out_q <= pos_x_out_d;
      pos_y_out_q <= pos_y_out_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign rd_en      = rd_en_q;
  assign gray_pixel = gray_q;
  assign pix_valid  = valid_q;
  assign pos_x_out  = pos_x_out_q;
  assign pos_y_out  = pos_y_out_q;

`ifdef GRAY_FETCH_MINMAX_EN
  logic [WORD_SIZE-1:0] run_min_q, run_min_d;
  logic [WORD_SIZE-1:0] run_max_q, run_max_d;
  logic                 seen_q, seen_d;
  logic [WORD_SIZE-1:0] frame_min_q, frame_min_d;
  logic [WORD_SIZE-1:0] frame_max_q, frame_max_d;
  logic                 frame_done_q, frame_done_d;

  // Track min/max of valid pixels. Publish them on the first pos_y_out == 0 cycle
  // after a frame that had valid pixels. pix_valid is never set on that row, so
  // publishing and accumulating cannot coincide.
  always_comb begin
    run_min_d    = run_min_q;
    run_max_d    = run_max_q;
    seen_d       = seen_q;
    frame_min_d  = frame_min_q;
    frame_max_d  = frame_max_q;
    frame_done_d = 1'b0;
    if ((pos_y_out_q == 11'd0) && seen_q) begin
      frame_min_d  = run_min_q;
      frame_max_d  = run_max_q;
      frame_done_d = 1'b1;
      run_min_d    = '1;
      run_max_d    = '0;
      seen_d       = 1'b0;
    end else if (valid_q) begin
      if (gray_q < run_min_q) run_min_d = gray_q;
      if (gray_q > run_max_q) run_max_d = gray_q;
      seen_d = 1'b1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_min_q    <= '1;
      run_max_q    <= '0;
      seen_q       <= 1'b0;
      frame_min_q  <= '0;
      frame_max_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      run_min_q    <= run_min_d;
      run_max_q    <= run_max_d;
      seen_q       <= seen_d;
      frame_min_q  <= frame_min_d;
      frame_max_q  <= frame_max_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_min  = frame_min_q;
  assign frame_max  = frame_max_q;
  assign frame_done = frame_done_q;
`endif

endmodule
